div_issue: RTL and testbench
============================

# div_issue

Issue-side controller for the multi-cycle integer divider in the EX stage. It accepts one DIV/DIVU/REM/REMU request from the pipeline and drives the divider's start/op/operand inputs. It holds start through the whole operation, takes the result over the divider's valid/ready output handshake, and presents a single writeback beat. It stalls the pipeline while busy and cleanly drains a flushed operation so the divider is never left mid-transaction.

## Interface
- DATA_W, 32, operand/result width (matches `RegBus`)
- RD_W, 5, destination register index width
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `req_valid_i`  in  1  divide request valid
- `req_ready_o`  out  1  request accepted when high with `req_valid_i`
- `req_op_i`  in  3  `INST_DIV`/`INST_DIVU`/`INST_REM`/`INST_REMU`
- `req_rs1_i`, `req_rs2_i`  in  DATA_W  dividend, divisor
- `req_rd_i`  in  RD_W  destination register
- `flush_i`  in  1  kill the in-flight operation
- `hold_o`  out  1  pipeline stall request
- `div_start_o`  out  1  divider start, held high for the whole operation
- `div_op_o`  out  3  registered op
- `div_dividend_o`, `div_divisor_o`  out  DATA_W  registered operands
- `div_result_i`  in  DATA_W  divider result
- `div_res_valid_i`  in  1  divider result valid
- `div_res_ready_o`  out  1  result accept
- `wb_valid_o`  out  1  writeback valid
- `wb_rd_o`  out  RD_W  writeback register
- `wb_data_o`  out  DATA_W  writeback data
- `wb_ready_i`  in  1  writeback accepted

## Operation
- The controller has four states: IDLE, BUSY, DRAIN and WB.
- **IDLE**
  - `req_ready_o`=1.
  - If `req_valid_i` is high and `flush_i` is low, latch op, rs1, rs2 and rd, then go to BUSY.
  - A request that arrives with `flush_i` high is not accepted.
- **BUSY**
  - `div_start_o`=1 and `div_res_ready_o`=1.
  - On `div_res_valid_i`, capture `div_result_i` into the wb data register and go to WB.
  - On `flush_i` with no valid result, go to DRAIN.
  - On `flush_i` together with `div_res_valid_i`, discard the result and go to IDLE.
- **DRAIN**
  - `div_start_o`=1 and `div_res_ready_o`=1.
  - On `div_res_valid_i`, discard the result and go to IDLE.
  - `flush_i` is ignored in this state.
  - DRAIN exists because some divider variants do not abort when start drops.
- **WB**
  - `wb_valid_o`=1, with `wb_rd_o`/`wb_data_o` held stable.
  - On `wb_ready_i`, go to IDLE.
  - On `flush_i`, go to IDLE without writing back.
- `div_start_o` must be low in the cycle after any result handshake. This prevents the divider from relaunching on a held start.
- `hold_o` = (state != IDLE).
- Divide-by-zero and signed overflow handling belongs to the divider. This block passes the result through unmodified.

## Timing
- **Reset** (`rst` high at a clock edge): state goes to IDLE. All outputs are 0, except `req_ready_o`=1 from the first cycle after reset.
- **Reset mid-operation:** the controller returns to IDLE and drops start immediately. The divider shares the same reset domain.
- **Latency**
  - Request accept (cycle 0) → `div_start_o` high at cycle 1.
  - Divider result valid at cycle N → `wb_valid_o` at N+1.
  - With `wb_ready_i` held high, the block is back in IDLE at N+2.
- Operands and op on the `div_*` outputs are stable from the first start cycle until the cycle after the handshake.
- Only one operation can be outstanding. There is no request pipelining.

## Configuration
- `DIV_ISSUE_BYPASS_EN`
  - **Defined:** if `req_rs2_i`==0 or ==1 at accept, the result is computed locally and the block goes straight to WB one cycle after accept, with `div_start_o` never asserted.
    - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → rs1.
    - Divisor 1: DIV/DIVU → rs1; REM/REMU → 0.
  - **Undefined:** every request goes through the divider.

## Structure
- Op encodings (`INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU`) and `RegBus` come from the shared defines file. Do not redefine them locally.
- State encodings are local one-hot parameters.
- One sub-module, `div_bypass`, holds the combinational small-divisor detect and result, and exists only under the macro.

## Test plan
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → one wb beat with data 0xFFFFFFFD. REM on the same operands → 0xFFFFFFFF. Start stays high continuously until the handshake, then is low the next cycle.
- DIVU rs1=100, rs2=0, macro off → wb data 0xFFFFFFFF from the divider. REMU → 100.
- `flush_i` pulsed 5 cycles into BUSY → the block enters DRAIN and start stays high until the divider's valid. No wb beat occurs. The next request, DIVU 100/7, writes back 14.
- `wb_ready_i` held low 10 cycles in WB → `wb_valid_o`, rd and data are stable and `hold_o` is high throughout. Exactly one beat is taken when ready rises.
- With `DIV_ISSUE_BYPASS_EN`: DIV 0x12345678/1 → `wb_valid_o` at cycle 1 with data 0x12345678 and `div_start_o` never high. REM x/1 → 0.
- `rst` asserted in BUSY → next cycle state is IDLE, `div_start_o`=0, `hold_o`=0, `req_ready_o`=1, and no wb beat occurs.

Source files
------------

// File: rtl/div_issue_pkg.sv
// div_issue_pkg: shared divide op encodings and register width for the EX-stage divider issue logic.
package div_issue_pkg;

    localparam int RegBus = 32;

    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    function automatic logic is_rem(input logic [2:0] op);
        return (op == INST_REM) || (op == INST_REMU);
    endfunction

endpackage

// File: rtl/div_bypass.sv
// div_bypass: small-divisor (0 or 1) detect and local result, built only with DIV_ISSUE_BYPASS_EN.
`ifdef DIV_ISSUE_BYPASS_EN
module div_bypass
    import div_issue_pkg::*;
#(
    parameter int DATA_W = RegBus
) (
    input  logic [2:0]        op,
    input  logic [DATA_W-1:0] rs1,
    input  logic [DATA_W-1:0] rs2,
    output logic              hit,
    output logic [DATA_W-1:0] result
);

    logic rem;

    assign rem    = is_rem(op);
    assign hit    = (rs2[DATA_W-1:1] == '0);
    // divisor 1: quotient rs1, remainder 0; divisor 0: quotient all ones, remainder rs1
    assign result = rs2[0] ? (rem ? '0 : rs1) : (rem ? rs1 : '1);

endmodule
`endif

// File: rtl/div_issue.sv
// div_issue: issue-side controller for the multi-cycle divider (start/op/operands, result handshake, single wb beat).
// Optional local small-divisor shortcut when DIV_ISSUE_BYPASS_EN is defined.
module div_issue
    import div_issue_pkg::*;
#(
    parameter int DATA_W = RegBus,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [2:0]        req_op_i,
    input  logic [DATA_W-1:0] req_rs1_i,
    input  logic [DATA_W-1:0] req_rs2_i,
    input  logic [RD_W-1:0]   req_rd_i,
    input  logic              flush_i,
    output logic              hold_o,
    output logic              div_start_o,
    output logic [2:0]        div_op_o,
    output logic [DATA_W-1:0] div_dividend_o,
    output logic [DATA_W-1:0] div_divisor_o,
    input  logic [DATA_W-1:0] div_result_i,
    input  logic              div_res_valid_i,
    output logic              div_res_ready_o,
    output logic              wb_valid_o,
    output logic [RD_W-1:0]   wb_rd_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic              wb_ready_i
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        BUSY  = 4'b0010,
        DRAIN = 4'b0100,
        WB    = 4'b1000
    } state_t;

    state_t            state;
    logic              byp_hit;
    logic [DATA_W-1:0] byp_res;

`ifdef DIV_ISSUE_BYPASS_EN
    div_bypass #(.DATA_W(DATA_W)) u_bypass (
        .op     (req_op_i),
        .rs1    (req_rs1_i),
        .rs2    (req_rs2_i),
        .hit    (byp_hit),
        .result (byp_res)
    );
`else
    assign byp_hit = 1'b0;
    assign byp_res = '0;
`endif

    // start and result-ready leave BUSY/DRAIN together, so start is low the cycle after any handshake
    assign req_ready_o     = (state == IDLE);
    assign hold_o          = (state != IDLE);
    assign div_start_o     = (state == BUSY) || (state == DRAIN);
    assign div_res_ready_o = div_start_o;
    assign wb_valid_o      = (state == WB);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            div_op_o       <= '0;
            div_dividend_o <= '0;
            div_divisor_o  <= '0;
            wb_rd_o        <= '0;
            wb_data_o      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid_i && !flush_i) begin
                    div_op_o       <= req_op_i;
                    div_dividend_o <= req_rs1_i;
                    div_divisor_o  <= req_rs2_i;
                    wb_rd_o        <= req_rd_i;
                    wb_data_o      <= byp_res;
                    state          <= byp_hit ? WB : BUSY;
                end
                BUSY: if (div_res_valid_i) begin
                    if (!flush_i) wb_data_o <= div_result_i;
                    state <= flush_i ? IDLE : WB;
                end else if (flush_i) begin
                    state <= DRAIN;
                end
                DRAIN: if (div_res_valid_i) state <= IDLE;
                WB: if (wb_ready_i || flush_i) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_issue.sv
// tb_div_issue: scoreboard bench for div_issue with a behavioural divider of programmable latency.
module tb_div_issue;
    import div_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [2:0]  req_op_i = '0;
    logic [31:0] req_rs1_i = '0;
    logic [31:0] req_rs2_i = '0;
    logic [4:0]  req_rd_i = '0;
    logic        flush_i = 1'b0;
    logic        hold_o;
    logic        div_start_o;
    logic [2:0]  div_op_o;
    logic [31:0] div_dividend_o;
    logic [31:0] div_divisor_o;
    logic [31:0] div_result_i;
    logic        div_res_valid_i;
    logic        div_res_ready_o;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        wb_ready_i = 1'b1;

    always #5 clk = ~clk;

    div_issue dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .req_op_i        (req_op_i),
        .req_rs1_i       (req_rs1_i),
        .req_rs2_i       (req_rs2_i),
        .req_rd_i        (req_rd_i),
        .flush_i         (flush_i),
        .hold_o          (hold_o),
        .div_start_o     (div_start_o),
        .div_op_o        (div_op_o),
        .div_dividend_o  (div_dividend_o),
        .div_divisor_o   (div_divisor_o),
        .div_result_i    (div_result_i),
        .div_res_valid_i (div_res_valid_i),
        .div_res_ready_o (div_res_ready_o),
        .wb_valid_o      (wb_valid_o),
        .wb_rd_o         (wb_rd_o),
        .wb_data_o       (wb_data_o),
        .wb_ready_i      (wb_ready_i)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    // behavioural divider: RISC-V semantics, result valid after lat cycles of held start
    function automatic logic [31:0] dmodel(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic rem;
        logic sgn;
        rem = (op == INST_REM) || (op == INST_REMU);
        sgn = (op == INST_DIV) || (op == INST_REM);
        if (b == 32'd0) return rem ? a : 32'hFFFFFFFF;
        if (sgn && a == 32'h80000000 && b == 32'hFFFFFFFF) return rem ? 32'd0 : a;
        if (sgn && rem) return $signed(a) % $signed(b);
        if (sgn) return $signed(a) / $signed(b);
        if (rem) return a % b;
        return a / b;
    endfunction

    int lat = 3;
    int cnt = 0;

    always @(posedge clk) begin
        if (rst || !div_start_o || (div_res_valid_i && div_res_ready_o)) cnt <= 0;
        else cnt <= cnt + 1;
    end

    assign div_res_valid_i = div_start_o && (cnt >= lat);
    assign div_result_i    = dmodel(div_op_o, div_dividend_o, div_divisor_o);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: protocol timing checks plus scoreboard pop on every wb beat
    logic p_acc = 1'b0, p_hs = 1'b0, p_expwb = 1'b0, p_start = 1'b0, drain = 1'b0;

    always @(negedge clk) begin
        logic hs;
        hs = div_res_valid_i && div_res_ready_o;
        if (rst) begin
            p_acc = 1'b0; p_hs = 1'b0; p_expwb = 1'b0; p_start = 1'b0; drain = 1'b0;
        end else begin
`ifdef DIV_ISSUE_BYPASS_EN
            if (p_acc) chk("accept_to_start_or_wb", {31'd0, div_start_o | wb_valid_o}, 32'd1);
`else
            if (p_acc) chk("accept_to_start", {31'd0, div_start_o}, 32'd1);
`endif
            if (p_hs) chk("start_low_after_handshake", {31'd0, div_start_o}, 32'd0);
            if (p_expwb) chk("wb_cycle_after_result", {31'd0, wb_valid_o}, 32'd1);
            if (p_start && !p_hs) chk("start_held", {31'd0, div_start_o}, 32'd1);
            if (wb_valid_o && wb_ready_i) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wb actual rd=%0d data=0x%08h required=no beat at %0t", wb_rd_o, wb_data_o, $time);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_rd", {27'd0, wb_rd_o}, {27'd0, e.rd});
                    chk("wb_data", wb_data_o, e.data);
                end
            end
            p_acc   = req_valid_i && req_ready_o && !flush_i;
            p_hs    = hs;
            p_expwb = hs && !flush_i && !drain;
            p_start = div_start_o;
            if (div_start_o && flush_i) drain = 1'b1;
            if (hs) drain = 1'b0;
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!req_ready_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp, input bit push);
        wait_ready();
        req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_rd_i = rd;
        req_valid_i = 1'b1;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        if (push) sb.push_back('{rd, exp});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (hold_o && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) begin
            checks++; failures++;
            $display("FAIL idle_timeout actual=hold required=idle");
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_hold", {31'd0, hold_o}, 32'd0);
        chk("rst_start", {31'd0, div_start_o}, 32'd0);
        chk("rst_res_ready", {31'd0, div_res_ready_o}, 32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        chk("rst_wb_data", wb_data_o, 32'd0);
        @(posedge clk); #1;

        lat = 4;
        issue(INST_DIV, 32'hFFFFFFF9, 32'd2, 5'd3, 32'hFFFFFFFD, 1'b1);
        wait_idle();
        issue(INST_REM, 32'hFFFFFFF9, 32'd2, 5'd4, 32'hFFFFFFFF, 1'b1);
        wait_idle();

        issue(INST_DIVU, 32'd100, 32'd0, 5'd5, 32'hFFFFFFFF, 1'b1);
        wait_idle();
        issue(INST_REMU, 32'd100, 32'd0, 5'd6, 32'd100, 1'b1);
        wait_idle();

        // flush five cycles into BUSY: drain without writeback
        lat = 20;
        issue(INST_DIVU, 32'd100, 32'd7, 5'd7, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        chk("drain_hold", {31'd0, hold_o}, 32'd1);
        chk("drain_start", {31'd0, div_start_o}, 32'd1);
        chk("drain_req_ready", {31'd0, req_ready_o}, 32'd0);
        wait_idle();
        lat = 3;
        issue(INST_DIVU, 32'd100, 32'd7, 5'd8, 32'd14, 1'b1);
        wait_idle();

        // wb back-pressure for 10 cycles
        wb_ready_i = 1'b0;
        issue(INST_DIV, 32'd1000, 32'hFFFFFFF6, 5'd9, 32'hFFFFFF9C, 1'b1);
        begin
            int n = 0;
            while (!wb_valid_o && n < 100) begin
                @(posedge clk); #1;
                n++;
            end
        end
        repeat (10) begin
            @(negedge clk);
            chk("stall_wb_valid", {31'd0, wb_valid_o}, 32'd1);
            chk("stall_wb_rd", {27'd0, wb_rd_o}, 32'd9);
            chk("stall_wb_data", wb_data_o, 32'hFFFFFF9C);
            chk("stall_hold", {31'd0, hold_o}, 32'd1);
        end
        @(posedge clk); #1 wb_ready_i = 1'b1;
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

`ifdef DIV_ISSUE_BYPASS_EN
        issue(INST_DIV, 32'h12345678, 32'd1, 5'd10, 32'h12345678, 1'b1);
        @(negedge clk);
        chk("byp_wb_cycle1", {31'd0, wb_valid_o}, 32'd1);
        chk("byp_no_start", {31'd0, div_start_o}, 32'd0);
        wait_idle();
        issue(INST_REM, 32'hDEADBEEF, 32'd1, 5'd12, 32'd0, 1'b1);
        @(negedge clk);
        chk("byp_rem_no_start", {31'd0, div_start_o}, 32'd0);
        wait_idle();
`endif

        // reset while BUSY
        lat = 50;
        issue(INST_DIV, 32'd50, 32'd5, 5'd11, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("rstbusy_start", {31'd0, div_start_o}, 32'd0);
        chk("rstbusy_hold", {31'd0, hold_o}, 32'd0);
        chk("rstbusy_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rstbusy_wb_valid", {31'd0, wb_valid_o}, 32'd0);
        repeat (60) @(posedge clk);
        #1;

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
